mult_pipe: RTL and testbench
============================

# mult_pipe

Parametrised, fully pipelined array multiplier with a valid/ready stream interface. It is the successor to the fixed 8-bit single-stage array multiplier. It splits the partial-product accumulation chain over a configurable number of register stages, supports backpressure, and optionally supports two's-complement operands. It sits in the datapath between a stream producer and consumer, and sustains one product per clock.

## Interface

**Parameters**
- `WIDTH`, 8: operand width. Product width is 2*WIDTH.
- `STAGES`, 4: number of accumulation stages. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0; otherwise elaboration fails.

**Ports**
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `a` in WIDTH: multiplicand.
- `b` in WIDTH: multiplier operand.
- `sgn` in 1: 1 = treat a, b as two's complement. Present only with `MULT_SIGNED_EN`.
- `in_valid` in 1: a, b, sgn are valid.
- `in_ready` out 1: block accepts input this cycle.
- `y` out 2*WIDTH: product.
- `out_valid` out 1: y is valid.
- `out_ready` in 1: consumer accepts y this cycle.

## Operation

- **Transfer rules**
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- **Pipeline structure**
  - Stage 0 (input register) captures a, b, sgn.
  - Stages 1..STAGES each add R = WIDTH/STAGES partial-product rows to the running sum of the previous stage and register it.
  - Stage k covers rows (k-1)*R .. k*R-1.
  - Row i = (a[i] ? b_ext << i : 0).
  - The stage STAGES register drives y.
- **Signed mode** (sgn=1)
  - b_ext is b sign-extended to 2*WIDTH.
  - Row WIDTH-1 is subtracted instead of added.
- **Unsigned mode**
  - b_ext is b zero-extended.
  - All rows are added.
- **Arithmetic**
  - All sums are modulo 2^(2*WIDTH).
  - The result equals the exact product for both modes; it cannot overflow.
- **Per-stage valid bit and flow control**
  - Each stage holds a valid bit v[k].
  - Stage k loads when `!v[k] || load[k+1]`.
  - The last stage loads when `!v[STAGES] || out_ready`.
  - This makes the pipeline bubble-collapsing: empty slots are filled even while the output is stalled.
- **Handshake outputs**
  - `in_ready` = load[0], and is forced to 0 while rst=1.
  - `out_valid` = v[STAGES].
- **Stability under stall**
  - While out_valid=1 and out_ready=0, y stays stable.
  - No valid stage is overwritten.
- **Ordering**: results emerge in input order; none are dropped or duplicated.
- **Reset**
  - All v[k] ← 0; all data registers ← 0.
  - Therefore y=0 and out_valid=0 in the cycle after rst is sampled high.
  - A reset asserted mid-operation discards all in-flight products.
  - The sgn register resets to 0.

## Timing

- **Latency**: a product accepted in cycle t appears with out_valid=1 in cycle t+STAGES+1, given out_ready held high.
- **Throughput**: 1 product/cycle sustained with out_ready=1.
- **Capacity**: STAGES+1 products are held when the output is stalled.
  - With a full pipeline and out_ready=0: in_ready=0.
  - With a full pipeline and out_ready=1: in_ready=1, so simultaneous accept and emit occur in the same cycle.
- **Combinational paths**
  - Ready path: out_ready → in_ready is combinational through STAGES+1 levels.
  - Critical data path: R row additions per stage.

## Configuration

- **`MULT_SIGNED_EN` defined**
  - `sgn` port exists.
  - Signed/unsigned mode is selectable per transaction and travels with the data through every stage.
- **`MULT_SIGNED_EN` undefined**
  - No `sgn` port and no sgn pipeline bits.
  - Unsigned only; all rows are added.

## Structure

- **Shared package `mult_pkg`** holds:
  - a function computing R and checking the parameter constraints;
  - a function building row i from a, b and sgn.
- **Sub-module `mult_stage`** (one accumulation stage). It takes:
  - parameters WIDTH, R and the first row index;
  - inputs: operands, sgn, incoming sum, incoming valid, load;
  - outputs: registered operands, sum and valid.

## Test plan

- **Unsigned latency** (WIDTH=8, STAGES=4, out_ready=1): a=255, b=255 at cycle t → y=0xFE01 with out_valid=1 at t+5, out_valid=0 at t+6.
- **Signed** (`MULT_SIGNED_EN`, sgn=1):
  - −128×−128 → 0x4000;
  - −1×1 → 0xFFFF;
  - 127×−128 → 0xC080.
  - Same operands with sgn=0: 255×1 → 0x00FF.
- **Streaming**: 100 random back-to-back pairs with out_ready=1 → 100 correct products in order, one per cycle, in_ready never 0.
- **Backpressure**: stream with out_ready=0 for 10 cycles → exactly 5 inputs accepted, then in_ready=0 and y stable; raise out_ready → 5 products in order, no gaps.
- **Bubble collapse**: stall the output with 2 products in flight, then insert 3 new inputs → all accepted before the stall releases; output order preserved.
- **Reset mid-operation**: 3 products in flight, rst high one cycle → next cycle out_valid=0 and y=0, and no stale product emerges afterwards.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined array multiplier: stage sizing and partial-product rows.
package mult_pkg;

  localparam int MAX_W  = 64;
  localparam int IDX_W  = $clog2(MAX_W);

  // Rows per stage, or 0 when the WIDTH/STAGES combination is not usable.
  function automatic int calc_r(input int width, input int stages);
    if (stages < 1 || stages > width || width > MAX_W) return 0;
    if (width % stages != 0) return 0;
    return width / stages;
  endfunction

  // Signed contribution of row i: the top row carries negative weight in signed mode.
  function automatic logic [2*MAX_W-1:0] mult_row(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             sgn,
    input int               width,
    input int               i
  );
    logic [2*MAX_W-1:0] b_ext;
    logic [2*MAX_W-1:0] row;
    b_ext = {{MAX_W{1'b0}}, b};
    if (sgn && b[IDX_W'(width - 1)])
      b_ext = b_ext | ({(2*MAX_W){1'b1}} << width);
    row = a[IDX_W'(i)] ? (b_ext << i) : '0;
    if (sgn && (i == width - 1))
      row = -row;
    return row;
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One accumulation stage: adds R partial-product rows to the incoming sum and registers it.
// Carries the per-transaction sgn bit only when MULT_SIGNED_EN is defined.
module mult_stage
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int R         = 2,
  parameter int FIRST_ROW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               sgn,
  output logic               sgn_reg,
`endif
  input  logic [2*WIDTH-1:0] sum,
  input  logic               valid,
  output logic [WIDTH-1:0]   a_reg,
  output logic [WIDTH-1:0]   b_reg,
  output logic [2*WIDTH-1:0] sum_reg,
  output logic               valid_reg
);

  logic               sgn_eff;
  logic [2*WIDTH-1:0] row [R];
  logic [2*WIDTH-1:0] sum_next;

`ifdef MULT_SIGNED_EN
  assign sgn_eff = sgn;
`else
  assign sgn_eff = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_row
      assign row[gi] = (2*WIDTH)'(mult_row(MAX_W'(a), MAX_W'(b), sgn_eff, WIDTH, FIRST_ROW + gi));
    end
  endgenerate

  always_comb begin
    sum_next = sum;
    for (int k = 0; k < R; k++)
      sum_next = sum_next + row[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
`ifdef MULT_SIGNED_EN
      sgn_reg   <= 1'b0;
`endif
    end else if (load) begin
      valid_reg <= valid;
      a_reg     <= a;
      b_reg     <= b;
      sum_reg   <= sum_next;
`ifdef MULT_SIGNED_EN
      sgn_reg   <= sgn;
`endif
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined array multiplier with valid/ready flow control and bubble collapsing.
// Optional two's-complement operands are enabled by defining MULT_SIGNED_EN.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int R = calc_r(WIDTH, STAGES);

  if (R == 0) begin : g_param_check
    $error("mult_pipe: need 1 <= STAGES <= WIDTH <= 64 and WIDTH %% STAGES == 0");
  end

  logic [WIDTH-1:0]   a0_reg;
  logic [WIDTH-1:0]   b0_reg;
  logic               v0_reg;
  logic [WIDTH-1:0]   a_stage   [STAGES+1];
  logic [WIDTH-1:0]   b_stage   [STAGES+1];
  logic [2*WIDTH-1:0] sum_stage [STAGES+1];
  logic [STAGES:0]    v;
  logic [STAGES:0]    load;
`ifdef MULT_SIGNED_EN
  logic               sgn0_reg;
  logic               sgn_stage [STAGES+1];
  assign sgn_stage[0] = sgn0_reg;
`endif

  assign a_stage[0]   = a0_reg;
  assign b_stage[0]   = b0_reg;
  assign sum_stage[0] = '0;
  assign v[0]         = v0_reg;

  // A stage may load if it is empty or its content moves on this cycle.
  assign load[STAGES] = !v[STAGES] || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_load
      assign load[gi] = !v[gi] || load[gi+1];
    end

    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      mult_stage #(
        .WIDTH     (WIDTH),
        .R         (R),
        .FIRST_ROW ((gi - 1) * R)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load[gi]),
        .a         (a_stage[gi-1]),
        .b         (b_stage[gi-1]),
`ifdef MULT_SIGNED_EN
        .sgn       (sgn_stage[gi-1]),
        .sgn_reg   (sgn_stage[gi]),
`endif
        .sum       (sum_stage[gi-1]),
        .valid     (v[gi-1]),
        .a_reg     (a_stage[gi]),
        .b_reg     (b_stage[gi]),
        .sum_reg   (sum_stage[gi]),
        .valid_reg (v[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_reg <= 1'b0;
      a0_reg <= '0;
      b0_reg <= '0;
`ifdef MULT_SIGNED_EN
      sgn0_reg <= 1'b0;
`endif
    end else if (load[0]) begin
      v0_reg <= in_valid;
      a0_reg <= a;
      b0_reg <= b;
`ifdef MULT_SIGNED_EN
      sgn0_reg <= sgn;
`endif
    end
  end

  assign in_ready  = load[0] && !rst;
  assign out_valid = v[STAGES];
  assign y         = sum_stage[STAGES];

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe (WIDTH=8, STAGES=4); signed vectors run when MULT_SIGNED_EN is defined.
module tb_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  int          first_out_cyc = 0;
  int          last_out_cyc  = 0;
  int          stall_cnt = 0;
  logic [15:0] exp_q [$];

  mult_pipe #(.WIDTH(8), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .sgn       (sgn),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic [15:0] ae;
    logic [15:0] be;
    ae = sv ? {{8{av[7]}}, av} : {8'b0, av};
    be = sv ? {{8{bv[7]}}, bv} : {8'b0, bv};
    return ae * be;
  endfunction

  // Scoreboard: every emitted product must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (n_out == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", {63'b0, out_valid}, 64'd0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        $display("out cyc=%0d y=0x%04h exp=0x%04h", cyc, y, e);
        check("y_order", {48'b0, y}, {48'b0, e});
      end
    end
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sv, input logic [15:0] ev);
    bit done;
    done = 0;
    a = av; b = bv; sgn = sv; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ev);
        done = 1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_accept", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0]  ua_tab [6] = '{8'd0, 8'd1, 8'd128, 8'd200, 8'd15, 8'd255};
  logic [7:0]  ub_tab [6] = '{8'd77, 8'd255, 8'd2, 8'd100, 8'd17, 8'd254};
  logic [15:0] uy_tab [6] = '{16'h0000, 16'h00FF, 16'h0100, 16'h4E20, 16'h00FF, 16'hFD02};

  initial begin
    int acc;
    logic [15:0] y_hold;
    logic [7:0]  av;
    logic [7:0]  bv;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b1;
    y_hold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y", {48'b0, y}, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Latency: accepted in cycle t, visible in t+5 only.
    @(posedge clk); #1;
    a = 8'd255; b = 8'd255; in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", {63'b0, in_ready}, 64'd1);
    exp_q.push_back(16'hFE01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 5) check("lat_early", {63'b0, out_valid}, 64'd0);
      if (k == 5) begin
        check("lat_valid", {63'b0, out_valid}, 64'd1);
        check("lat_y", {48'b0, y}, 64'hFE01);
      end
      if (k == 6) check("lat_after", {63'b0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) send(ua_tab[i], ub_tab[i], 1'b0, uy_tab[i]);
    idle(10);
    check("drain_unsigned", exp_q.size(), 64'd0);

`ifdef MULT_SIGNED_EN
    send(8'h80, 8'h80, 1'b1, 16'h4000);
    send(8'hFF, 8'h01, 1'b1, 16'hFFFF);
    send(8'h7F, 8'h80, 1'b1, 16'hC080);
    send(8'hFF, 8'h01, 1'b0, 16'h00FF);
    idle(10);
    check("drain_signed", exp_q.size(), 64'd0);
`endif

    // Streaming: 100 back-to-back products.
    n_out = 0; stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      send(av, bv, 1'b0, model(av, bv, 1'b0));
    end
    idle(10);
    check("stream_count", n_out, 64'd100);
    check("stream_span", last_out_cyc - first_out_cyc, 64'd99);
    check("stream_stalls", stall_cnt, 64'd0);

    // Backpressure: output held for 10 cycles.
    out_ready = 1'b0; n_out = 0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      a = 8'(10 + acc); b = 8'(3 + 7 * acc); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, 1'b0));
        acc++;
      end
      if (c == 6) y_hold = y;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted", acc, 64'd5);
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
    check("bp_y_stable", {48'b0, y}, {48'b0, y_hold});
    check("bp_no_emit", n_out, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    idle(10);
    check("bp_drained", n_out, 64'd5);
    check("bp_no_gaps", last_out_cyc - first_out_cyc, 64'd4);

    // Bubble collapse: two stalled products, three more must still fit.
    out_ready = 1'b0; n_out = 0; stall_cnt = 0;
    send(8'd9, 8'd11, 1'b0, 16'd99);
    send(8'd250, 8'd3, 1'b0, 16'd750);
    idle(8);
    send(8'd16, 8'd16, 1'b0, 16'h0100);
    send(8'd100, 8'd100, 1'b0, 16'h2710);
    send(8'd255, 8'd2, 1'b0, 16'h01FE);
    @(negedge clk);
    check("bubble_stalls", stall_cnt, 64'd0);
    check("bubble_full", {63'b0, in_ready}, 64'd0);
    check("bubble_no_emit", n_out, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(10);
    check("bubble_drained", n_out, 64'd5);

    // Reset with three products in flight.
    n_out = 0;
    send(8'd3, 8'd5, 1'b0, 16'd15);
    send(8'd7, 8'd7, 1'b0, 16'd49);
    send(8'd12, 8'd12, 1'b0, 16'd144);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_y", {48'b0, y}, 64'd0);
    idle(10);
    check("mid_rst_no_stale", n_out, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
